led7seg_scan: RTL and testbench
===============================

// Module: led7seg_scan
// PURPOSE
//  Time-multiplexed driver for a 4-digit common-anode 7-segment display; produces LED/SA.
//  Holds four hex digits plus decimal points. Scans one digit per refresh slot and decodes it to segments.
//  New values are taken only at frame boundaries, so a frame never tears.
//  Sits between the value producer (counters, switch logic) and the display pins.
// PARAMETERS
//  CLK_DIV  50000  clocks per digit slot (>=2); frame period = 4*CLK_DIV clocks
// PORTS
//  CLK    in   1   system clock, all logic on rising edge
//  RST    in   1   synchronous reset, active-high
//  DATA   in   16  four hex digits; DATA[3:0] = digit 0 (rightmost, SA[0])
//  DP     in   4   decimal point per digit, 1 = lit
//  BLANK  in   4   per-digit blank request, 1 = digit dark
//  LOAD   in   1   1-cycle strobe: capture DATA/DP/BLANK into pending register
//  BUSY   out  1   pending value not yet applied to display
//  FRAME  out  1   1-cycle pulse at each frame boundary (digit 3 -> digit 0)
//  LED    out  8   segments, active-low; bit0=a,1=b,2=c,3=d,4=e,5=f,6=g,7=dp
//  SA     out  4   digit anodes, active-low; at most one bit low at any time
// BEHAVIOUR
//  - Reset: cnt=0, idx=0, shadow/pending=0, BUSY=0, FRAME=0, LED=8'hFF, SA=4'b1111.
//  - Prescaler cnt counts 0..CLK_DIV-1 and wraps; tick = (cnt==CLK_DIV-1).
//  - On tick: idx <= idx+1 (wraps 3->0); LED/SA registers forced to 8'hFF/4'b1111
//    for that one cycle (dead time, anti-ghost).
//  - Other cycles: SA <= ~(1<<idx); LED <= ~{dp, seg(digit idx)}, both registered.
//    Result: each digit is lit CLK_DIV-1 cycles, then dark 1 cycle.
//  - A blanked digit drives SA=4'b1111 and LED=8'hFF for its whole slot.
//  - Boundary = tick while idx==3; FRAME=1 in the cycle after the boundary.
//  - LOAD (no boundary): pending <= inputs, BUSY <= 1; a repeated LOAD overwrites pending (last wins).
//  - Boundary with BUSY=1 and no LOAD: shadow <= pending, BUSY <= 0.
//  - LOAD coincident with boundary: shadow <= inputs directly, pending <= inputs, BUSY <= 0.
//  - The display always shows shadow, never pending.
//  - RST mid-frame: all state returns to reset values next edge; pending value discarded.
//  - Decode: standard hex 0-F (0=C0,1=F9,2=A4,3=B0,4=99,5=92,6=82,7=F8,8=80,9=90,
//    A=88,b=83,C=C6,d=A1,E=86,F=8E, active-low with dp off).
// CONFIGURATION
//  `LED7SEG_LZB_EN defined: leading-zero blanking. Digits 3..1 whose value is 0, and whose
//    more-significant digits are all 0, are treated as BLANK. Digit 0 is never blanked by this rule.
//    A lit DP on a digit cancels its blanking.
//  Undefined: every digit is shown as decoded; only BLANK darkens a digit.
// STRUCTURE
//  - Shared include led7seg_defs.vh: segment bit positions, active-low OFF constants (8'hFF, 4'hF),
//    hex->segment table values.
//  - Sub-module led7seg_hex_decode: combinational 4-bit hex -> 7-bit active-high segments;
//    the top level inverts it and appends dp.
//  - Top level: prescaler, digit index, pending/shadow registers, output registers.
// TESTING (bench uses CLK_DIV=4)
//  1. RST high 3 cycles -> LED=8'hFF, SA=4'b1111, BUSY=0, FRAME=0 throughout.
//  2. LOAD DATA=16'h1234, DP=0, BLANK=0 while idle -> BUSY=1 until boundary, then 0.
//     Digit 0 slot: SA=4'b1110, LED=8'h99. Digit 3 slot: SA=4'b0111, LED=8'hF9.
//  3. Scan order after reset -> SA: 1110 x3, 1111, 1101 x3, 1111, 1011 x3, 1111, 0111 x3, 1111, repeat.
//     FRAME pulses every 16 clocks.
//  4. LOAD 16'hAAAA then 16'h5555 in one frame -> next frame shows 5 (LED=8'h92) on all digits.
//     LOAD coincident with boundary -> new value visible in the same frame, BUSY never rises.
//  5. DATA=16'h0007, DP=0 -> with LED7SEG_LZB_EN: digits 3..1 SA=1111/LED=FF, digit 0 LED=8'hF8.
//     Without the macro: digits 3..1 LED=8'hC0. With DP=4'b0100: digit 2 lit, LED=8'h40.
//  6. RST asserted mid-frame with BUSY=1 -> next cycle outputs off, BUSY=0.
//     After release the display shows 0000 (LED=8'hC0), not the pending value.

Source files
------------

// File: rtl/led7seg_pkg.sv
// Shared types and helpers for the 4-digit multiplexed 7-segment display driver.
package led7seg_pkg;

  // One complete display image: four hex digits, per-digit decimal points and blank requests.
  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } disp_t;

  // Digits 3..1 that are zero with only zeros above them; digit 0 is never marked.
  function automatic logic [3:0] lz_mask(input logic [15:0] data);
    logic [3:0] m;
    m[3] = (data[15:12] == 4'h0);
    m[2] = m[3] && (data[11:8] == 4'h0);
    m[1] = m[2] && (data[7:4] == 4'h0);
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/led7seg_defs.vh
// Segment bit positions, active-low "all off" constants and the hex -> active-high segment table.
`ifndef LED7SEG_DEFS_VH
`define LED7SEG_DEFS_VH

`define LED7_BIT_A   0
`define LED7_BIT_B   1
`define LED7_BIT_C   2
`define LED7_BIT_D   3
`define LED7_BIT_E   4
`define LED7_BIT_F   5
`define LED7_BIT_G   6
`define LED7_BIT_DP  7

`define LED7_LED_OFF 8'hFF
`define LED7_SA_OFF  4'hF

`define LED7_HEX_0 7'h3F
`define LED7_HEX_1 7'h06
`define LED7_HEX_2 7'h5B
`define LED7_HEX_3 7'h4F
`define LED7_HEX_4 7'h66
`define LED7_HEX_5 7'h6D
`define LED7_HEX_6 7'h7D
`define LED7_HEX_7 7'h07
`define LED7_HEX_8 7'h7F
`define LED7_HEX_9 7'h6F
`define LED7_HEX_A 7'h77
`define LED7_HEX_B 7'h7C
`define LED7_HEX_C 7'h39
`define LED7_HEX_D 7'h5E
`define LED7_HEX_E 7'h79
`define LED7_HEX_F 7'h71

`endif

// File: rtl/led7seg_hex_decode.sv
// Combinational hex digit -> active-high segments {g,f,e,d,c,b,a}.
`include "led7seg_defs.vh"

module led7seg_hex_decode (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = `LED7_HEX_0;
    case (hex)
      4'h0: seg = `LED7_HEX_0;
      4'h1: seg = `LED7_HEX_1;
      4'h2: seg = `LED7_HEX_2;
      4'h3: seg = `LED7_HEX_3;
      4'h4: seg = `LED7_HEX_4;
      4'h5: seg = `LED7_HEX_5;
      4'h6: seg = `LED7_HEX_6;
      4'h7: seg = `LED7_HEX_7;
      4'h8: seg = `LED7_HEX_8;
      4'h9: seg = `LED7_HEX_9;
      4'hA: seg = `LED7_HEX_A;
      4'hB: seg = `LED7_HEX_B;
      4'hC: seg = `LED7_HEX_C;
      4'hD: seg = `LED7_HEX_D;
      4'hE: seg = `LED7_HEX_E;
      4'hF: seg = `LED7_HEX_F;
      default: seg = `LED7_HEX_0;
    endcase
  end

endmodule

// File: rtl/led7seg_scan.sv
// 4-digit common-anode scanner: one digit per CLK_DIV-clock slot, 1-cycle dead time, frame-aligned updates.
// LED7SEG_LZB_EN defined enables leading-zero blanking of digits 3..1.
`include "led7seg_defs.vh"

module led7seg_scan
  import led7seg_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] DATA,
  input  logic [3:0]  DP,
  input  logic [3:0]  BLANK,
  input  logic        LOAD,
  output logic        BUSY,
  output logic        FRAME,
  output logic [7:0]  LED,
  output logic [3:0]  SA
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  disp_t         shadow;
  disp_t         pending;
  disp_t         in_val;
  logic          busy_q;
  logic          frame_q;
  logic [7:0]    led_q;
  logic [3:0]    sa_q;

  logic          tick;
  logic          boundary;
  logic [3:0]    eff_blank;
  logic [3:0]    cur_hex;
  logic [6:0]    seg;

  assign in_val   = '{data: DATA, dp: DP, blank: BLANK};
  assign tick     = (cnt == CW'(CLK_DIV - 1));
  assign boundary = tick && (idx == 2'd3);
  assign cur_hex  = shadow.data[{idx, 2'b00} +: 4];

`ifdef LED7SEG_LZB_EN
  // A lit decimal point keeps an otherwise suppressed leading zero visible.
  assign eff_blank = shadow.blank | (lz_mask(shadow.data) & ~shadow.dp);
`else
  assign eff_blank = shadow.blank;
`endif

  led7seg_hex_decode u_dec (
    .hex (cur_hex),
    .seg (seg)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt     <= '0;
      idx     <= 2'd0;
      shadow  <= '0;
      pending <= '0;
      busy_q  <= 1'b0;
      frame_q <= 1'b0;
      led_q   <= `LED7_LED_OFF;
      sa_q    <= `LED7_SA_OFF;
    end else begin
      cnt     <= tick ? '0 : cnt + CW'(1);
      frame_q <= boundary;
      if (tick) idx <= idx + 2'd1;

      // A load landing on the boundary bypasses pending so it shows in the frame just starting.
      if (LOAD) begin
        pending <= in_val;
        if (boundary) begin
          shadow <= in_val;
          busy_q <= 1'b0;
        end else begin
          busy_q <= 1'b1;
        end
      end else if (boundary && busy_q) begin
        shadow <= pending;
        busy_q <= 1'b0;
      end

      // The last cycle of every slot is dark so the anode switch never ghosts the next digit.
      if (tick || eff_blank[idx]) begin
        led_q <= `LED7_LED_OFF;
        sa_q  <= `LED7_SA_OFF;
      end else begin
        led_q <= ~{shadow.dp[idx], seg};
        sa_q  <= ~(4'b0001 << idx);
      end
    end
  end

  assign BUSY  = busy_q;
  assign FRAME = frame_q;
  assign LED   = led_q;
  assign SA    = sa_q;

endmodule

// File: tb/tb_led7seg_scan.sv
// Randomised and directed bench for led7seg_scan against a frame-level reference model.
module tb_led7seg_scan;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        load;
  logic        busy;
  logic        frame;
  logic [7:0]  led;
  logic [3:0]  sa;

  led7seg_scan #(.CLK_DIV(DIV)) dut (
    .CLK   (clk),
    .RST   (rst),
    .DATA  (data),
    .DP    (dp),
    .BLANK (blank),
    .LOAD  (load),
    .BUSY  (busy),
    .FRAME (frame),
    .LED   (led),
    .SA    (sa)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          e;
    logic [15:0] d;
    logic [3:0]  p;
    logic [3:0]  b;
  } ld_t;

  ld_t  q[$];
  int   k;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [7:0] exp_led;
  logic [3:0] exp_sa;
  logic       exp_busy;
  logic       exp_frame;

  // Active-low hex glyphs, dp off.
  function automatic logic [7:0] glyph(input logic [3:0] h);
    case (h)
      4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
      4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
      4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
      4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  // Edge index of the first frame boundary at or after edge e.
  function automatic int bnd(input int e);
    return e + (4 * DIV - 1 - (e % (4 * DIV)));
  endfunction

  task automatic model(input int kk);
    ld_t v;
    int  d;
    bit  dark;
    v = '{0, 16'h0, 4'h0, 4'h0};
    foreach (q[i]) if (bnd(q[i].e) < kk) v = q[i];
    exp_busy  = (q.size() > 0) && (bnd(q[q.size()-1].e) > kk);
    exp_frame = ((kk % (4 * DIV)) == 4 * DIV - 1);
    d    = (kk / DIV) % 4;
    dark = ((kk % DIV) == DIV - 1) || v.b[d];
`ifdef LED7SEG_LZB_EN
    if (d != 0 && ((v.d >> (4 * d)) == 16'h0) && !v.p[d]) dark = 1'b1;
`endif
    if (dark) begin
      exp_led = 8'hFF;
      exp_sa  = 4'hF;
    end else begin
      exp_led = glyph(4'((v.d >> (4 * d)) & 16'hF)) & (v.p[d] ? 8'h7F : 8'hFF);
      exp_sa  = 4'hF & ~(4'b0001 << d);
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) begin
      q.delete();
      exp_led = 8'hFF; exp_sa = 4'hF; exp_busy = 1'b0; exp_frame = 1'b0;
      k = 0;
    end else begin
      if (load) q.push_back('{k, data, dp, blank});
      model(k);
      k++;
    end
    #1;
    chk("led",   16'(led),   16'(exp_led));
    chk("sa",    16'(sa),    16'(exp_sa));
    chk("busy",  16'(busy),  16'(exp_busy));
    chk("frame", 16'(frame), 16'(exp_frame));
    chk("sa_onehot", 16'($countones(~sa) <= 1), 16'd1);
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    data = d; dp = p; blank = b; load = 1'b1;
    cyc();
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; data = '0; dp = '0; blank = '0; k = 0;
    // Reset held for three cycles
    run(3);
    rst = 1'b0;
    run(5);
    // Basic load while idle, then full scan of two frames
    do_load(16'h1234, 4'h0, 4'h0);
    run(40);
    // Last-wins within one frame
    while (k % 16 == 15 || k % 16 == 14) cyc();
    do_load(16'hAAAA, 4'h0, 4'h0);
    run(3);
    do_load(16'h5555, 4'h0, 4'h0);
    run(36);
    // Load coincident with the frame boundary
    while (k % 16 != 15) cyc();
    do_load(16'hC0DE, 4'h0, 4'h0);
    run(20);
    // Leading zeros, then decimal point on digit 2, then explicit blanks
    do_load(16'h0007, 4'h0, 4'h0);
    run(34);
    do_load(16'h0007, 4'b0100, 4'h0);
    run(34);
    do_load(16'hBEEF, 4'b1001, 4'b0010);
    run(34);
    // Reset mid-frame with a pending value outstanding
    while (k % 16 == 15 || k % 16 == 14) cyc();
    do_load(16'h9876, 4'hF, 4'h0);
    run(1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    run(24);
    // Random traffic with occasional resets
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
      end else if ($urandom_range(0, 9) == 0) begin
        do_load(16'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0);
      end else begin
        cyc();
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
